// File: rtl/cnn_pkg.sv
// Shared types, default sizes, per-class bias table and saturating helpers for the classifier.
// The bias table is consumed only when the BIAS_EN macro is defined.
package cnn_pkg;

  localparam int unsigned N_CLASS_DEF = 10;
  localparam int unsigned DATA_W_DEF  = 16;
  localparam int unsigned IDX_W_DEF   = 4;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StCommit
  } state_e;

  localparam logic signed [DATA_W_DEF-1:0] BIAS [N_CLASS_DEF] = '{
    16'sh0000, 16'sh0000, 16'sh0000, 16'sh0000, 16'sh0000,
    16'sh0300, 16'sh0000, 16'sh0000, 16'sh0000, 16'sh0000
  };

  // Signed add clamped to the representable range.
  function automatic logic signed [DATA_W_DEF-1:0] sat_add(
    input logic signed [DATA_W_DEF-1:0] a,
    input logic signed [DATA_W_DEF-1:0] b
  );
    logic [DATA_W_DEF:0] s;
    s = {a[DATA_W_DEF-1], a} + {b[DATA_W_DEF-1], b};
    if (s[DATA_W_DEF] != s[DATA_W_DEF-1]) begin
      return s[DATA_W_DEF] ? {1'b1, {(DATA_W_DEF-1){1'b0}}} : {1'b0, {(DATA_W_DEF-1){1'b1}}};
    end
    return s[DATA_W_DEF-1:0];
  endfunction

  // a - b with a wide intermediate, clamped to [0, max positive].
  function automatic logic signed [DATA_W_DEF-1:0] sat_sub(
    input logic signed [DATA_W_DEF-1:0] a,
    input logic signed [DATA_W_DEF-1:0] b
  );
    logic [DATA_W_DEF:0] d;
    d = {a[DATA_W_DEF-1], a} - {b[DATA_W_DEF-1], b};
    if (d[DATA_W_DEF]) return '0;
    if (d[DATA_W_DEF-1]) return {1'b0, {(DATA_W_DEF-1){1'b1}}};
    return d[DATA_W_DEF-1:0];
  endfunction

endpackage

// File: rtl/argmax_classifier_cmp.sv
// Combinational compare-and-update of the running best/second against one lane.
// Strict greater-than keeps the lower index on ties.
module argmax_cmp
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned IDX_W  = IDX_W_DEF
) (
  input  logic signed [DATA_W-1:0] lane_i,
  input  logic        [IDX_W-1:0]  idx_i,
  input  logic signed [DATA_W-1:0] best_i,
  input  logic        [IDX_W-1:0]  best_idx_i,
  input  logic signed [DATA_W-1:0] second_i,
  output logic signed [DATA_W-1:0] best_o,
  output logic        [IDX_W-1:0]  best_idx_o,
  output logic signed [DATA_W-1:0] second_o
);

  always_comb begin
    best_o     = best_i;
    best_idx_o = best_idx_i;
    second_o   = second_i;
    if (lane_i > best_i) begin
      second_o   = best_i;
      best_o     = lane_i;
      best_idx_o = idx_i;
    end else if (lane_i > second_i) begin
      second_o = lane_i;
    end
  end

endmodule

// File: rtl/argmax_classifier.sv
// Sequential argmax over captured logits: one lane per clock, reports class, score and margin.
// Define BIAS_EN to add a saturating per-class bias at capture time.
module argmax_classifier
  import cnn_pkg::*;
#(
  parameter int unsigned N_CLASS = N_CLASS_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned IDX_W   = IDX_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [N_CLASS*DATA_W-1:0] fl_vec,
  output logic                      busy,
  output logic                      done,
  output logic [IDX_W-1:0]          class_id,
  output logic [DATA_W-1:0]         class_score,
  output logic [DATA_W-1:0]         margin
);

  state_e state_q, state_d;
  logic signed [DATA_W-1:0] lane_q [N_CLASS];
  logic signed [DATA_W-1:0] lane_d [N_CLASS];
  logic signed [DATA_W-1:0] cap_lane [N_CLASS];
  logic signed [DATA_W-1:0] best_q, best_d, second_q, second_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d, idx_q, idx_d;
  logic done_q, done_d;
  logic [IDX_W-1:0] class_id_q, class_id_d;
  logic [DATA_W-1:0] score_q, score_d, margin_q, margin_d;
  logic signed [DATA_W-1:0] cmp_best, cmp_second;
  logic [IDX_W-1:0] cmp_best_idx;

  for (genvar k = 0; k < N_CLASS; k++) begin : g_cap
`ifdef BIAS_EN
    assign cap_lane[k] = sat_add(fl_vec[k*DATA_W +: DATA_W], BIAS[k]);
`else
    assign cap_lane[k] = fl_vec[k*DATA_W +: DATA_W];
`endif
  end

  argmax_cmp #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_cmp (
    .lane_i     (lane_q[idx_q]),
    .idx_i      (idx_q),
    .best_i     (best_q),
    .best_idx_i (best_idx_q),
    .second_i   (second_q),
    .best_o     (cmp_best),
    .best_idx_o (cmp_best_idx),
    .second_o   (cmp_second)
  );

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    second_d   = second_q;
    idx_d      = idx_q;
    done_d     = 1'b0;
    class_id_d = class_id_q;
    score_d    = score_q;
    margin_d   = margin_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          lane_d     = cap_lane;
          best_d     = cap_lane[0];
          best_idx_d = '0;
          second_d   = {1'b1, {(DATA_W-1){1'b0}}};
          idx_d      = IDX_W'(1);
          state_d    = StScan;
        end
      end
      StScan: begin
        best_d     = cmp_best;
        best_idx_d = cmp_best_idx;
        second_d   = cmp_second;
        idx_d      = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(N_CLASS - 1)) state_d = StCommit;
      end
      StCommit: begin
        class_id_d = best_idx_q;
        score_d    = best_q;
        margin_d   = sat_sub(best_q, second_q);
        done_d     = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      lane_q     <= '{default: '0};
      best_q     <= '0;
      best_idx_q <= '0;
      second_q   <= '0;
      idx_q      <= '0;
      done_q     <= 1'b0;
      class_id_q <= '0;
      score_q    <= '0;
      margin_q   <= '0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      second_q   <= second_d;
      idx_q      <= idx_d;
      done_q     <= done_d;
      class_id_q <= class_id_d;
      score_q    <= score_d;
      margin_q   <= margin_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign class_id    = class_id_q;
  assign class_score = score_q;
  assign margin      = margin_q;

endmodule

// File: tb/tb_argmax_classifier.sv
// Scoreboard bench for argmax_classifier: directed + random logit vectors against a max/second model.
module tb_argmax_classifier;
  import cnn_pkg::*;

  localparam int N = 10;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [N*W-1:0] fl_vec = '0;
  logic busy, done;
  logic [3:0] class_id;
  logic [W-1:0] class_score, margin;

  argmax_classifier dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .fl_vec      (fl_vec),
    .busy        (busy),
    .done        (done),
    .class_id    (class_id),
    .class_score (class_score),
    .margin      (margin)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int id;
    int score;
    int margin;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: biased lane values, first maximum wins, second = max of the remaining lanes.
  function automatic exp_t model(input logic [N*W-1:0] v);
    exp_t e;
    int val[N];
    int bi, sec, m;
    for (int k = 0; k < N; k++) begin
      val[k] = int'($signed(v[k*W +: W]));
`ifdef BIAS_EN
      val[k] += int'(BIAS[k]);
      if (val[k] > 32767) val[k] = 32767;
      if (val[k] < -32768) val[k] = -32768;
`endif
    end
    bi = 0;
    for (int k = 1; k < N; k++) if (val[k] > val[bi]) bi = k;
    sec = -32768;
    for (int k = 0; k < N; k++) if (k != bi && val[k] > sec) sec = val[k];
    m = val[bi] - sec;
    if (m > 32767) m = 32767;
    e.id = bi;
    e.score = val[bi] & 16'hFFFF;
    e.margin = m;
    e.cyc = 0;
    return e;
  endfunction

  function automatic logic [N*W-1:0] rand_vec();
    logic [N*W-1:0] v;
    logic [W-1:0] pool [4];
    pool[0] = 16'h0400; pool[1] = 16'hFC00; pool[2] = 16'h0000; pool[3] = 16'h0401;
    for (int k = 0; k < N; k++) begin
      case ($urandom_range(0, 3))
        0: v[k*W +: W] = W'($urandom);
        1: v[k*W +: W] = pool[$urandom_range(0, 3)];
        2: v[k*W +: W] = $urandom_range(0, 1) ? 16'h7FFF : 16'h8000;
        default: v[k*W +: W] = W'($urandom_range(0, 16'h0FFF));
      endcase
    end
    return v;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no pending result (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        chk("class_id", int'(class_id), e.id);
        chk("class_score", int'(class_score), e.score);
        chk("margin", int'(margin), e.margin);
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  // Issue one scan from a negedge; returns at the negedge of its done cycle.
  task automatic scan(input logic [N*W-1:0] v, input bit poke);
    exp_t e;
    e = model(v);
    e.cyc = cyc + 11;
    sb.push_back(e);
    fl_vec = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    fl_vec = rand_vec();
    chk("busy_scan", int'(busy), 1);
    for (int j = 2; j <= 11; j++) begin
      if (poke && j == 4) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*W-1:0] v;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_class_id", int'(class_id), 0);
    chk("rst_score", int'(class_score), 0);
    chk("rst_margin", int'(margin), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    @(negedge clk);

    for (int k = 0; k < N; k++) v[k*W +: W] = W'((k + 1) << 8);
    scan(v, 1'b0);
    for (int k = 0; k < N; k++) v[k*W +: W] = (k == 3) ? 16'hFF80 : 16'hFF00;
    scan(v, 1'b1);
    for (int k = 0; k < N; k++) v[k*W +: W] = (k == 2 || k == 7) ? 16'h0400 : 16'h0000;
    scan(v, 1'b0);
    for (int k = 0; k < N; k++) v[k*W +: W] = (k == 0) ? 16'h7FFF : 16'h8000;
    scan(v, 1'b0);
    for (int k = 0; k < N; k++) v[k*W +: W] = (k == 5) ? 16'h7E00 : 16'h0000;
    scan(v, 1'b0);

    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      scan(rand_vec(), ($urandom_range(0, 3) == 0));
    end

    for (int k = 0; k < N; k++) v[k*W +: W] = W'((k + 1) << 8);
    scan(v, 1'b0);
    @(negedge clk);

    // Abort a scan with reset; no result may follow.
    fl_vec = rand_vec();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_class_id", int'(class_id), 0);
    chk("abort_score", int'(class_score), 0);
    chk("abort_margin", int'(margin), 0);
    chk("abort_busy", int'(busy), 0);
    repeat (15) @(negedge clk);

    for (int k = 0; k < N; k++) v[k*W +: W] = (k == 2 || k == 7) ? 16'h0400 : 16'h0000;
    scan(v, 1'b0);
    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
